// File: rtl/hamming_secded_pipe.sv
// Multi-lane SECDED encoder with XOR error injector; 2-cycle accept->o_valid latency.
// Both stages advance together whenever the output register is empty or draining; otherwise everything holds.
module hamming_secded_pipe #(
  parameter int NUM_LANES    = 2,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_BITS  = $clog2(DATA_BITS) + 1,
  parameter int ENCODED_WORD = DATA_BITS + PARITY_BITS,
  parameter int CNT_W        = 16
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [NUM_LANES*DATA_BITS-1:0]         i_data,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [NUM_LANES*(ENCODED_WORD+1)-1:0]  o_dout,
  input  logic                                   i_inj_load,
  input  logic [1:0]                             i_inj_mode,
  input  logic [NUM_LANES*(ENCODED_WORD+1)-1:0]  i_inj_mask,
  input  logic [CNT_W-1:0]                       i_inj_period,
  output logic [CNT_W-1:0]                       o_inj_cnt,
  output logic                                   o_inj_armed
);

  localparam int LW    = ENCODED_WORD + 1;
  localparam int OUT_W = NUM_LANES * LW;
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if ((2 ** PARITY_BITS) < (DATA_BITS + PARITY_BITS + 1)) begin : g_param_chk
    $error("PARITY_BITS too small to cover DATA_BITS");
  end

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ARMED    = 2'd1,
    ST_PERSIST  = 2'd2,
    ST_PERIODIC = 2'd3
  } inj_st_e;

  function automatic logic [LW-1:0] encode(input logic [DATA_BITS-1:0] d);
    logic [LW-1:0] w;
    logic          p;
    int            di;
    w  = '0;
    di = 0;
    for (int pos = 1; pos <= ENCODED_WORD; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[pos-1] = d[di];
        di++;
      end
    end
    // Parity slots are still zero here, and no other parity slot has bit k set.
    for (int k = 0; k < PARITY_BITS; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= ENCODED_WORD; pos++) begin
        if (((pos >> k) & 1) == 1) p = p ^ w[pos-1];
      end
      w[(1<<k)-1] = p;
    end
    w[ENCODED_WORD] = ^w[ENCODED_WORD-1:0];
    return w;
  endfunction

  logic             s1_vld_q, s1_vld_d;
  logic [OUT_W-1:0] s1_dat_q, s1_dat_d;
  logic             o_vld_q, o_vld_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  inj_st_e          st_q, st_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             adv;
  logic             move;
  logic             inject;
  logic             hit;
  logic [CNT_W-1:0] per_eff;
  logic [OUT_W-1:0] enc_all;

  always_comb begin
    enc_all = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      enc_all[n*LW +: LW] = encode(i_data[n*DATA_BITS +: DATA_BITS]);
    end
  end

  always_comb begin
    adv     = !o_vld_q | i_ready;
    move    = adv & s1_vld_q;
    per_eff = (period_q == '0) ? ONE : period_q;
    hit     = (pcnt_q == (per_eff - ONE));

    case (st_q)
      ST_ARMED:    inject = 1'b1;
      ST_PERSIST:  inject = 1'b1;
      ST_PERIODIC: inject = hit;
      default:     inject = 1'b0;
    endcase

    s1_vld_d = s1_vld_q;
    s1_dat_d = s1_dat_q;
    o_vld_d  = o_vld_q;
    dout_d   = dout_q;
    st_d     = st_q;
    mask_d   = mask_q;
    period_d = period_q;
    pcnt_d   = pcnt_q;
    cnt_d    = cnt_q;

    if (adv) begin
      s1_vld_d = i_valid;
      if (i_valid) s1_dat_d = enc_all;
      o_vld_d = s1_vld_q;
      if (s1_vld_q) dout_d = inject ? (s1_dat_q ^ mask_q) : s1_dat_q;
    end

    if (move) begin
      if (inject && (cnt_q != CNT_MAX)) cnt_d = cnt_q + ONE;
      if (st_q == ST_ARMED) st_d = ST_OFF;
      if (st_q == ST_PERIODIC) pcnt_d = hit ? '0 : (pcnt_q + ONE);
    end

    // A load lands after this cycle's move and overrides any one-shot consumption.
    if (i_inj_load) begin
      st_d     = inj_st_e'(i_inj_mode);
      mask_d   = i_inj_mask;
      period_d = i_inj_period;
      pcnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      o_vld_q  <= 1'b0;
      dout_q   <= '0;
      st_q     <= ST_OFF;
      mask_q   <= '0;
      period_q <= '0;
      pcnt_q   <= '0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
      o_vld_q  <= o_vld_d;
      dout_q   <= dout_d;
      st_q     <= st_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      pcnt_q   <= pcnt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_ready     = !o_vld_q | i_ready;
  assign o_valid     = o_vld_q;
  assign o_dout      = dout_q;
  assign o_inj_cnt   = cnt_q;
  assign o_inj_armed = (st_q == ST_ARMED);

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Bench for hamming_secded_pipe: random words against a syndrome-based reference encoder
// and a per-word injection model; outputs are collected on the falling edge.
module tb_hamming_secded_pipe;
  localparam int LW = 13;
  localparam int OW = 26;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [OW-1:0] o_dout;
  logic          i_inj_load = 1'b0;
  logic [1:0]    i_inj_mode = 2'd0;
  logic [OW-1:0] i_inj_mask = '0;
  logic [CW-1:0] i_inj_period = '0;
  logic [CW-1:0] o_inj_cnt;
  logic          o_inj_armed;

  always #5 clk = ~clk;

  hamming_secded_pipe #(.NUM_LANES(2), .DATA_BITS(8), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_dout(o_dout), .i_inj_load(i_inj_load),
    .i_inj_mode(i_inj_mode), .i_inj_mask(i_inj_mask), .i_inj_period(i_inj_period),
    .o_inj_cnt(o_inj_cnt), .o_inj_armed(o_inj_armed)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Output collector: only this process writes these.
  logic [OW-1:0] got_q[$];
  int            got_cyc[$];
  int            cyc = 0;
  int            hold_viol = 0;
  int            rdy_viol = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_dout = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (o_valid !== 1'b1 || o_dout !== prev_dout)) hold_viol++;
      if (o_ready !== (!o_valid | i_ready)) rdy_viol++;
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
        got_q.push_back(o_dout);
        got_cyc.push_back(cyc);
      end
      prev_stall = (o_valid === 1'b1) && !i_ready;
      prev_dout  = o_dout;
    end
  end

  // Reference model
  logic [OW-1:0] exp_q[$];
  int            rd_ptr = 0;
  logic [1:0]    m_mode = 2'd0;
  logic [OW-1:0] m_mask = '0;
  int            m_per = 0;
  int            m_idx = 0;
  int            m_cnt = 0;
  bit            m_armed = 1'b0;

  // Parity bit k is bit k of the XOR of the positions of all set data bits.
  function automatic logic [LW-1:0] ref_enc(input logic [7:0] d);
    int            dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [LW-1:0] w = '0;
    int            s = 0;
    for (int j = 0; j < 8; j++) begin
      if (d[j]) begin
        w[dpos[j]-1] = 1'b1;
        s = s ^ dpos[j];
      end
    end
    w[0] = s[0];
    w[1] = s[1];
    w[3] = s[2];
    w[7] = s[3];
    w[12] = ^w[11:0];
    return w;
  endfunction

  function automatic logic [OW-1:0] clean(input logic [DW-1:0] d);
    return {ref_enc(d[15:8]), ref_enc(d[7:0])};
  endfunction

  task automatic model_load(input logic [1:0] mode, input logic [OW-1:0] mask, input int per);
    m_mode  = mode;
    m_mask  = mask;
    m_per   = (per == 0) ? 1 : per;
    m_idx   = 0;
    m_armed = (mode == 2'd1);
  endtask

  task automatic model_push(input logic [DW-1:0] d);
    logic [OW-1:0] e;
    bit            inj;
    e = clean(d);
    case (m_mode)
      2'd1:    inj = m_armed;
      2'd2:    inj = 1'b1;
      2'd3:    inj = ((m_idx % m_per) == m_per - 1);
      default: inj = 1'b0;
    endcase
    m_armed = 1'b0;
    m_idx++;
    if (inj) begin
      e = e ^ m_mask;
      if (m_cnt < 15) m_cnt++;
    end
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int t;
    i_valid = 1'b1;
    i_data  = d;
    t = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (o_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout o_ready=%b required 1", o_ready);
    end else begin
      model_push(d);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic load_inj(input logic [1:0] mode, input logic [OW-1:0] mask, input logic [CW-1:0] per);
    i_inj_load   = 1'b1;
    i_inj_mode   = mode;
    i_inj_mask   = mask;
    i_inj_period = per;
    @(posedge clk);
    #1;
    i_inj_load = 1'b0;
    model_load(mode, mask, int'(per));
  endtask

  task automatic drain(input int nexp);
    for (int t = 0; t < 300 && (got_q.size() - rd_ptr) < nexp; t++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic sb_flush();
    rd_ptr = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b need 0", o_valid); end
    n_cmp++; if (o_dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h need 0", o_dout); end
    n_cmp++; if (o_inj_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d need 0", o_inj_cnt); end
    n_cmp++; if (o_inj_armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed got %b need 0", o_inj_armed); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b need 1", o_ready); end
  endtask

  task automatic test_basic();
    i_valid = 1'b1;
    i_data  = {8'hFF, 8'hA5};
    @(negedge clk);
    model_push(i_data);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1 valid got %b need 0", o_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_lat2 valid got %b need 1", o_valid); end
    n_cmp++;
    if (o_dout !== {13'h0F77, 13'h0A27}) begin
      n_fail++; $display("FAIL basic_dout got %h need %h", o_dout, {13'h0F77, 13'h0A27});
    end
    drain(exp_q.size());
    n_cmp++;
    if (got_q.size() - rd_ptr != 1 || got_q[rd_ptr] !== exp_q[0]) begin
      n_fail++; $display("FAIL basic_model got %0d words, first %h need %h", got_q.size() - rd_ptr, got_q[rd_ptr], exp_q[0]);
    end
    sb_flush();
  endtask

  task automatic test_zero();
    send_word(16'h0000);
    drain(exp_q.size());
    n_cmp++;
    if (got_q.size() - rd_ptr != 1 || got_q[rd_ptr] !== '0) begin
      n_fail++; $display("FAIL zero_word got %h (count %0d) need 0", got_q[rd_ptr], got_q.size() - rd_ptr);
    end
    sb_flush();
  endtask

  task automatic test_back_to_back();
    int base;
    base = got_q.size();
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_word(DW'($urandom));
    drain(exp_q.size());
    n_cmp++;
    if (got_q.size() - base != 16) begin
      n_fail++; $display("FAIL b2b_count got %0d need 16", got_q.size() - base);
    end else begin
      n_cmp++;
      if (got_cyc[base+15] - got_cyc[base] != 15) begin
        n_fail++; $display("FAIL b2b_gaps span got %0d need 15", got_cyc[base+15] - got_cyc[base]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[rd_ptr+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_word%0d got %h need %h", i, got_q[rd_ptr+i], exp_q[i]);
      end
    end
    sb_flush();
  endtask

  task automatic test_stall();
    int base;
    base = got_q.size();
    i_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send_word(DW'($urandom));
      end
      begin
        for (int t = 0; t < 60 && got_q.size() < base + 3; t++) @(posedge clk);
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_cmp++;
          if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_flags valid=%b ready=%b need 1/0", o_valid, o_ready);
          end
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain(exp_q.size());
    n_cmp++;
    if (got_q.size() - rd_ptr != 10) begin
      n_fail++; $display("FAIL stall_count got %0d need 10", got_q.size() - rd_ptr);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[rd_ptr+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL stall_word%0d got %h need %h", i, got_q[rd_ptr+i], exp_q[i]);
      end
    end
    n_cmp++; if (hold_viol !== 0) begin n_fail++; $display("FAIL stall_hold violations %0d need 0", hold_viol); end
    n_cmp++; if (rdy_viol !== 0) begin n_fail++; $display("FAIL ready_eq violations %0d need 0", rdy_viol); end
    sb_flush();
  endtask

  task automatic test_one_shot();
    load_inj(2'd1, {13'h0000, 13'h0004}, '0);
    n_cmp++; if (o_inj_armed !== 1'b1) begin n_fail++; $display("FAIL oneshot_armed got %b need 1", o_inj_armed); end
    for (int i = 0; i < 4; i++) send_word({8'hFF, 8'hA5});
    drain(exp_q.size());
    n_cmp++;
    if (got_q[rd_ptr] !== {13'h0F77, 13'h0A23}) begin
      n_fail++; $display("FAIL oneshot_first got %h need %h", got_q[rd_ptr], {13'h0F77, 13'h0A23});
    end
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if (got_q[rd_ptr+i] !== {13'h0F77, 13'h0A27}) begin
        n_fail++; $display("FAIL oneshot_clean%0d got %h need %h", i, got_q[rd_ptr+i], {13'h0F77, 13'h0A27});
      end
    end
    n_cmp++; if (o_inj_cnt !== 4'd1) begin n_fail++; $display("FAIL oneshot_cnt got %0d need 1", o_inj_cnt); end
    n_cmp++; if (o_inj_armed !== 1'b0) begin n_fail++; $display("FAIL oneshot_disarm got %b need 0", o_inj_armed); end
    sb_flush();
  endtask

  task automatic test_load_timing();
    logic [OW-1:0] mask_x;
    logic [OW-1:0] mask_y;
    mask_x = {13'h1000, 13'h0000};
    mask_y = {13'h0000, 13'h0001};
    load_inj(2'd1, mask_x, '0);
    i_valid = 1'b1;
    i_data  = DW'($urandom);
    @(negedge clk);
    model_push(i_data);
    @(posedge clk);
    #1;
    // New one-shot load coincides with the first word's move: first word uses the old mask.
    i_data       = DW'($urandom);
    i_inj_load   = 1'b1;
    i_inj_mode   = 2'd1;
    i_inj_mask   = mask_y;
    i_inj_period = '0;
    @(negedge clk);
    model_load(2'd1, mask_y, 0);
    model_push(i_data);
    @(posedge clk);
    #1;
    i_valid    = 1'b0;
    i_inj_load = 1'b0;
    n_cmp++; if (o_inj_armed !== 1'b1) begin n_fail++; $display("FAIL loadwins_armed got %b need 1", o_inj_armed); end
    drain(exp_q.size());
    n_cmp++;
    if (got_q.size() - rd_ptr != 2) begin
      n_fail++; $display("FAIL loadtime_count got %0d need 2", got_q.size() - rd_ptr);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[rd_ptr+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL loadtime_word%0d got %h need %h", i, got_q[rd_ptr+i], exp_q[i]);
      end
    end
    n_cmp++; if (o_inj_cnt !== 4'd3) begin n_fail++; $display("FAIL loadtime_cnt got %0d need 3", o_inj_cnt); end
    sb_flush();
  endtask

  task automatic test_periodic();
    logic [DW-1:0] w[9];
    logic [OW-1:0] mask;
    logic [OW-1:0] e;
    mask = {13'h0100, 13'h0810};
    load_inj(2'd3, mask, 4'd3);
    for (int i = 0; i < 9; i++) begin
      w[i] = DW'($urandom);
      send_word(w[i]);
    end
    drain(exp_q.size());
    for (int i = 0; i < 9; i++) begin
      e = ((i % 3) == 2) ? (clean(w[i]) ^ mask) : clean(w[i]);
      n_cmp++;
      if (got_q[rd_ptr+i] !== e) begin
        n_fail++; $display("FAIL periodic3_word%0d got %h need %h", i + 1, got_q[rd_ptr+i], e);
      end
    end
    n_cmp++; if (o_inj_cnt !== 4'd6) begin n_fail++; $display("FAIL periodic3_cnt got %0d need 6", o_inj_cnt); end
    sb_flush();
    load_inj(2'd3, mask, 4'd0);
    for (int i = 0; i < 4; i++) begin
      w[i] = DW'($urandom);
      send_word(w[i]);
    end
    drain(exp_q.size());
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_q[rd_ptr+i] !== (clean(w[i]) ^ mask)) begin
        n_fail++; $display("FAIL periodic0_word%0d got %h need %h", i, got_q[rd_ptr+i], clean(w[i]) ^ mask);
      end
    end
    n_cmp++; if (o_inj_cnt !== 4'd10) begin n_fail++; $display("FAIL periodic0_cnt got %0d need 10", o_inj_cnt); end
    sb_flush();
  endtask

  task automatic test_random();
    bit done;
    for (int r = 0; r < 4; r++) begin
      load_inj(2'($urandom_range(0, 3)), OW'({$urandom, $urandom}), 4'($urandom_range(0, 4)));
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 15; i++) send_word(DW'($urandom));
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1;
            i_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      i_ready = 1'b1;
      drain(exp_q.size());
      n_cmp++;
      if (got_q.size() - rd_ptr != 15) begin
        n_fail++; $display("FAIL random%0d_count got %0d need 15", r, got_q.size() - rd_ptr);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[rd_ptr+i] !== exp_q[i]) begin
          n_fail++; $display("FAIL random%0d_word%0d got %h need %h", r, i, got_q[rd_ptr+i], exp_q[i]);
        end
      end
      n_cmp++;
      if (int'(o_inj_cnt) != m_cnt) begin
        n_fail++; $display("FAIL random%0d_cnt got %0d need %0d", r, o_inj_cnt, m_cnt);
      end
      sb_flush();
    end
    n_cmp++; if (hold_viol !== 0) begin n_fail++; $display("FAIL random_hold violations %0d need 0", hold_viol); end
  endtask

  task automatic test_saturate();
    load_inj(2'd2, {13'h1FFF, 13'h0000}, '0);
    for (int i = 0; i < 16; i++) send_word(DW'($urandom));
    drain(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[rd_ptr+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL persist_word%0d got %h need %h", i, got_q[rd_ptr+i], exp_q[i]);
      end
    end
    n_cmp++; if (o_inj_cnt !== 4'hF) begin n_fail++; $display("FAIL saturate_cnt got %0d need 15", o_inj_cnt); end
    sb_flush();
    load_inj(2'd0, '0, '0);
  endtask

  task automatic test_reset_midstream();
    i_ready = 1'b1;
    load_inj(2'd2, {13'h0000, 13'h0002}, '0);
    send_word(DW'($urandom));
    send_word(DW'($urandom));
    rst = 1'b1;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b need 0", o_valid); end
    n_cmp++; if (o_inj_cnt !== '0) begin n_fail++; $display("FAIL midrst_cnt got %0d need 0", o_inj_cnt); end
    n_cmp++; if (o_dout !== '0) begin n_fail++; $display("FAIL midrst_dout got %h need 0", o_dout); end
    sb_flush();
    model_load(2'd0, '0, 0);
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != rd_ptr) begin
      n_fail++; $display("FAIL midrst_flush got %0d outputs need 0", got_q.size() - rd_ptr);
    end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after got %b need 0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_stall();
    test_one_shot();
    test_load_timing();
    test_periodic();
    test_random();
    test_saturate();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
